// File: rtl/queue_reader.sv
// queue_reader: consumer end of the 8-deep byte queue in the 10 kHz domain.
// Watches queue occupancy, issues one-cycle dequeue pulses, captures the popped
// byte one cycle later and presents it downstream on a valid/ready handshake.
// Keeps a delivered-byte count and a modulo-2^DATA_W checksum.
//
// Ports:
//   clk_10khz       in   1       clock, rising edge
//   reset           in   1       asynchronous, active-high reset
//   enable_in       in   1       1 = may start new pops; 0 = finish current byte then park
//   q_len_in        in   LEN_W   queue occupancy (queue len_out)
//   q_data_in       in   DATA_W  queue registered popped byte (queue data_out)
//   q_dequeue_out   out  1       registered one-cycle dequeue pulse to the queue
//   data_out        out  DATA_W  byte presented downstream
//   valid_out       out  1       data_out holds an undelivered byte
//   ready_in        in   1       downstream accepts when valid_out & ready_in at an edge
//   byte_count_out  out  CNT_W   bytes delivered since reset (wraps)
//   checksum_out    out  DATA_W  sum of delivered bytes (wraps)
//   busy_out        out  1       1 whenever the FSM is not idle
module queue_reader #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              clk_10khz,
    input  logic              reset,
    input  logic              enable_in,
    input  logic [LEN_W-1:0]  q_len_in,
    input  logic [DATA_W-1:0] q_data_in,
    output logic              q_dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  byte_count_out,
    output logic [DATA_W-1:0] checksum_out,
    output logic              busy_out
);

    // Gap counter only needs to hold GAP_CYCLES-1; keep at least one bit.
    localparam int unsigned     GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_e;

    state_e             state_q;
    logic [GAP_W-1:0]   gap_q;

    // Single registered FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk_10khz or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            gap_q          <= '0;
            q_dequeue_out  <= 1'b0;
            data_out       <= '0;
            valid_out      <= 1'b0;
            byte_count_out <= '0;
            checksum_out   <= '0;
            busy_out       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Occupancy is only looked at here, so at most one byte is ever in flight.
                    if (enable_in && (q_len_in != '0)) begin
                        state_q       <= S_POP;
                        q_dequeue_out <= 1'b1;
                        busy_out      <= 1'b1;
                    end
                end
                S_POP: begin
                    state_q       <= S_WAIT;
                    q_dequeue_out <= 1'b0;
                end
                S_WAIT: begin
                    // Queue's data_out register now holds the popped byte.
                    state_q   <= S_HOLD;
                    data_out  <= q_data_in;
                    valid_out <= 1'b1;
                end
                S_HOLD: begin
                    if (ready_in) begin
                        valid_out      <= 1'b0;
                        byte_count_out <= byte_count_out + CNT_W'(1);
                        checksum_out   <= checksum_out + data_out;
                        if (GAP_CYCLES > 0) begin
                            state_q <= S_GAP;
                            gap_q   <= GAP_LOAD;
                        end else begin
                            state_q  <= S_IDLE;
                            busy_out <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q  <= S_IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    q_dequeue_out <= 1'b0;
                    valid_out     <= 1'b0;
                    busy_out      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: behavioural byte queue feeding two instances
// (GAP_CYCLES=0 and GAP_CYCLES=3) with a byte scoreboard per instance.
`timescale 1ns/1ps
module tb_queue_reader;

    logic       clk_10khz = 1'b0;
    logic       reset     = 1'b1;

    logic       en0 = 1'b0, ready0 = 1'b0, deq0, valid0, busy0;
    logic [3:0] len0 = 4'd0;
    logic [7:0] qd0 = 8'd0, data0, sum0;
    logic [15:0] cnt0;

    logic       en1 = 1'b0, ready1 = 1'b0, deq1, valid1, busy1;
    logic [3:0] len1 = 4'd0;
    logic [7:0] qd1 = 8'd0, data1, sum1;
    logic [15:0] cnt1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] qm0[$], sb0[$], qm1[$], sb1[$];
    int deq_t0[$], hs_t0[$], deq_t1[$], hs_t1[$];
    int vcyc0, first_v0;

    always #50 clk_10khz = ~clk_10khz;

    queue_reader #(.DATA_W(8), .LEN_W(4), .CNT_W(16), .GAP_CYCLES(0)) dut0 (
        .clk_10khz(clk_10khz), .reset(reset), .enable_in(en0), .q_len_in(len0),
        .q_data_in(qd0), .q_dequeue_out(deq0), .data_out(data0), .valid_out(valid0),
        .ready_in(ready0), .byte_count_out(cnt0), .checksum_out(sum0), .busy_out(busy0)
    );

    queue_reader #(.DATA_W(8), .LEN_W(4), .CNT_W(16), .GAP_CYCLES(3)) dut1 (
        .clk_10khz(clk_10khz), .reset(reset), .enable_in(en1), .q_len_in(len1),
        .q_data_in(qd1), .q_dequeue_out(deq1), .data_out(data1), .valid_out(valid1),
        .ready_in(ready1), .byte_count_out(cnt1), .checksum_out(sum1), .busy_out(busy1)
    );

    // One clock: sample outputs #1 after the previous edge, then apply the queue pop.
    task automatic cycle();
        logic       d0, d1, h0, h1;
        logic [7:0] e;
        d0 = deq0; d1 = deq1;
        h0 = valid0 && ready0;
        h1 = valid1 && ready1;
        if (d0) begin
            deq_t0.push_back(cyc);
            checks++;
            if (qm0.size() == 0) begin
                failures++;
                $display("FAIL deq_at_empty0 cyc=%0d got dequeue=1 want 0", cyc);
            end
        end
        if (d1) begin
            deq_t1.push_back(cyc);
            checks++;
            if (qm1.size() == 0) begin
                failures++;
                $display("FAIL deq_at_empty1 cyc=%0d got dequeue=1 want 0", cyc);
            end
        end
        if (valid0) begin
            vcyc0++;
            if (first_v0 < 0) first_v0 = cyc;
        end
        if (h0) begin
            hs_t0.push_back(cyc);
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("FAIL sb_byte0 cyc=%0d got %02h want <none>", cyc, data0);
            end else begin
                e = sb0.pop_front();
                if (data0 !== e) begin
                    failures++;
                    $display("FAIL sb_byte0 cyc=%0d got %02h want %02h", cyc, data0, e);
                end
            end
        end
        if (h1) begin
            hs_t1.push_back(cyc);
            checks++;
            if (sb1.size() == 0) begin
                failures++;
                $display("FAIL sb_byte1 cyc=%0d got %02h want <none>", cyc, data1);
            end else begin
                e = sb1.pop_front();
                if (data1 !== e) begin
                    failures++;
                    $display("FAIL sb_byte1 cyc=%0d got %02h want %02h", cyc, data1, e);
                end
            end
        end
        @(posedge clk_10khz);
        #1;
        cyc++;
        if (d0 && qm0.size() > 0) qd0 = qm0.pop_front();
        if (d1 && qm1.size() > 0) qd1 = qm1.pop_front();
        len0 = 4'(qm0.size());
        len1 = 4'(qm1.size());
    endtask

    task automatic clear_track();
        deq_t0.delete(); hs_t0.delete(); deq_t1.delete(); hs_t1.delete();
        vcyc0 = 0; first_v0 = -1;
    endtask

    task automatic clear_queues();
        qm0.delete(); sb0.delete(); qm1.delete(); sb1.delete();
        len0 = 4'd0; len1 = 4'd0; qd0 = 8'd0; qd1 = 8'd0;
    endtask

    task automatic load0(input logic [7:0] b);
        qm0.push_back(b); sb0.push_back(b); len0 = 4'(qm0.size());
    endtask

    task automatic load1(input logic [7:0] b);
        qm1.push_back(b); sb1.push_back(b); len1 = 4'(qm1.size());
    endtask

    task automatic apply_reset();
        #10 reset = 1'b1;
        #20 reset = 1'b0;
        clear_queues();
        clear_track();
        cycle();
        clear_track();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(); cycle();
        checks++;
        if ({deq0, valid0, busy0, data0, cnt0, sum0} !== 35'd0) begin
            failures++;
            $display("FAIL reset_init got %h want 0", {deq0, valid0, busy0, data0, cnt0, sum0});
        end
        reset = 1'b0;
        clear_track();
        // Drive into HOLD with a pending byte, then reset asynchronously.
        en0 = 1'b1; ready0 = 1'b0;
        load0(8'h11);
        for (int i = 0; i < 10 && !valid0; i++) cycle();
        checks++;
        if (valid0 !== 1'b1 || data0 !== 8'h11) begin
            failures++;
            $display("FAIL reset_reach_hold got valid=%b data=%02h want 1/11", valid0, data0);
        end
        #10 reset = 1'b1;
        #1;
        checks++;
        if (valid0 !== 1'b0 || data0 !== 8'h00) begin
            failures++;
            $display("FAIL reset_async_valid got valid=%b data=%02h want 0/00", valid0, data0);
        end
        checks++;
        if ({deq0, busy0, cnt0, sum0} !== 26'd0) begin
            failures++;
            $display("FAIL reset_async_rest got %h want 0", {deq0, busy0, cnt0, sum0});
        end
        #9 reset = 1'b0;
        en0 = 1'b0;
        clear_queues();
        clear_track();
        cycle();
        checks++;
        if (busy0 !== 1'b0 || deq0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b deq=%b want 0/0", busy0, deq0);
        end
    endtask

    task automatic test_single();
        clear_track();
        en0 = 1'b1; ready0 = 1'b1;
        load0(8'hA5);
        for (int i = 0; i < 20 && hs_t0.size() < 1; i++) cycle();
        cycle(); cycle();
        checks++;
        if (hs_t0.size() != 1 || deq_t0.size() != 1) begin
            failures++;
            $display("FAIL single_counts got hs=%0d deq=%0d want 1/1", hs_t0.size(), deq_t0.size());
        end
        checks++;
        if (deq_t0.size() < 1 || (first_v0 - deq_t0[0]) != 2) begin
            failures++;
            $display("FAIL single_latency got valid_cyc=%0d want deq_cyc+2", first_v0);
        end
        checks++;
        if (vcyc0 != 1) begin
            failures++;
            $display("FAIL single_valid_len got %0d want 1", vcyc0);
        end
        checks++;
        if (cnt0 !== 16'd1 || sum0 !== 8'hA5) begin
            failures++;
            $display("FAIL single_totals got cnt=%0d sum=%02h want 1/a5", cnt0, sum0);
        end
        checks++;
        if (data0 !== 8'hA5 || valid0 !== 1'b0) begin
            failures++;
            $display("FAIL single_data_kept got data=%02h valid=%b want a5/0", data0, valid0);
        end
    endtask

    task automatic test_backpressure();
        clear_track();
        en0 = 1'b1; ready0 = 1'b0;
        load0(8'h31); load0(8'h32); load0(8'h33);
        for (int i = 0; i < 10 && !valid0; i++) cycle();
        checks++;
        if (valid0 !== 1'b1) begin
            failures++;
            $display("FAIL bp_valid_reach got %b want 1", valid0);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid0 !== 1'b1 || data0 !== 8'h31) begin
                failures++;
                $display("FAIL bp_stable i=%0d got valid=%b data=%02h want 1/31", i, valid0, data0);
            end
            cycle();
        end
        checks++;
        if (deq_t0.size() != 1) begin
            failures++;
            $display("FAIL bp_one_pulse got %0d want 1", deq_t0.size());
        end
        ready0 = 1'b1;
        for (int i = 0; i < 40 && hs_t0.size() < 3; i++) cycle();
        checks++;
        if (hs_t0.size() != 3 || deq_t0.size() != 3) begin
            failures++;
            $display("FAIL bp_drain got hs=%0d deq=%0d want 3/3", hs_t0.size(), deq_t0.size());
        end
        checks++;
        if (deq_t0.size() < 2 || hs_t0.size() < 1 || (deq_t0[1] - hs_t0[0]) != 2) begin
            failures++;
            $display("FAIL bp_next_pop got gap=%0d want 2",
                     (deq_t0.size() > 1 && hs_t0.size() > 0) ? deq_t0[1] - hs_t0[0] : -1);
        end
    endtask

    task automatic test_burst();
        apply_reset();
        en0 = 1'b1; ready0 = 1'b1;
        for (int b = 1; b <= 8; b++) load0(8'(b));
        for (int i = 0; i < 80 && hs_t0.size() < 8; i++) cycle();
        for (int i = 0; i < 6; i++) cycle();
        checks++;
        if (deq_t0.size() != 8 || hs_t0.size() != 8) begin
            failures++;
            $display("FAIL burst_counts got deq=%0d hs=%0d want 8/8", deq_t0.size(), hs_t0.size());
        end
        if (deq_t0.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                checks++;
                if ((deq_t0[i] - deq_t0[i-1]) != 4) begin
                    failures++;
                    $display("FAIL burst_spacing i=%0d got %0d want 4", i, deq_t0[i] - deq_t0[i-1]);
                end
            end
        end
        checks++;
        if (cnt0 !== 16'd8 || sum0 !== 8'h24) begin
            failures++;
            $display("FAIL burst_totals got cnt=%0d sum=%02h want 8/24", cnt0, sum0);
        end
    endtask

    task automatic test_gap();
        clear_track();
        en1 = 1'b1; ready1 = 1'b1;
        load1(8'hC3); load1(8'h3C);
        for (int i = 0; i < 40 && hs_t1.size() < 2; i++) cycle();
        for (int i = 0; i < 8; i++) cycle();
        checks++;
        if (deq_t1.size() != 2 || hs_t1.size() != 2) begin
            failures++;
            $display("FAIL gap_counts got deq=%0d hs=%0d want 2/2", deq_t1.size(), hs_t1.size());
        end
        checks++;
        if (deq_t1.size() < 2 || (deq_t1[1] - deq_t1[0]) != 7) begin
            failures++;
            $display("FAIL gap_spacing got %0d want 7",
                     (deq_t1.size() > 1) ? deq_t1[1] - deq_t1[0] : -1);
        end
        checks++;
        if (cnt1 !== 16'd2 || sum1 !== 8'hFF || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL gap_totals got cnt=%0d sum=%02h busy=%b want 2/ff/0", cnt1, sum1, busy1);
        end
    endtask

    task automatic test_enable_wrap();
        apply_reset();
        en0 = 1'b0; ready0 = 1'b1;
        load0(8'hFF); load0(8'h02); load0(8'h10); load0(8'h20); load0(8'h30);
        for (int i = 0; i < 10; i++) cycle();
        checks++;
        if (deq_t0.size() != 0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL en_off_idle got deq=%0d busy=%b want 0/0", deq_t0.size(), busy0);
        end
        en0 = 1'b1;
        for (int i = 0; i < 5 && deq_t0.size() < 1; i++) cycle();
        en0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || deq0 !== 1'b0 || valid0 !== 1'b0) begin
            failures++;
            $display("FAIL en_in_wait got busy=%b deq=%b valid=%b want 1/0/0", busy0, deq0, valid0);
        end
        for (int i = 0; i < 15; i++) cycle();
        checks++;
        if (hs_t0.size() != 1 || deq_t0.size() != 1) begin
            failures++;
            $display("FAIL en_drop_finish got hs=%0d deq=%0d want 1/1", hs_t0.size(), deq_t0.size());
        end
        checks++;
        if (cnt0 !== 16'd1 || sum0 !== 8'hFF || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_totals got cnt=%0d sum=%02h busy=%b want 1/ff/0", cnt0, sum0, busy0);
        end
        en0 = 1'b1;
        for (int i = 0; i < 20 && hs_t0.size() < 2; i++) cycle();
        en0 = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        checks++;
        if (cnt0 !== 16'd2 || sum0 !== 8'h01 || deq_t0.size() != 2) begin
            failures++;
            $display("FAIL wrap_checksum got cnt=%0d sum=%02h deq=%0d want 2/01/2",
                     cnt0, sum0, deq_t0.size());
        end
    endtask

    initial begin
        #1;
        clear_track();
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_gap();
        test_enable_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
